// File: rtl/alu_pkg.sv
// Shared ALU constants: opcodes, PSR bit positions, opcode classes and the
// opcode-to-class decoder used by the writeback stage.
package alu_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 16;
  localparam int FLAG_W   = 5;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  localparam int PSR_Z = 4;
  localparam int PSR_C = 3;
  localparam int PSR_F = 2;
  localparam int PSR_N = 1;
  localparam int PSR_L = 0;

  localparam logic [7:0] OP_WAIT = 8'h00;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_LSH  = 8'h04;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_RSH  = 8'h0C;
  localparam logic [7:0] OP_ALSH = 8'h0D;
  localparam logic [7:0] OP_ARSH = 8'h0E;
  localparam logic [7:0] OP_LSHI = 8'h84;

  typedef enum logic [2:0] {
    CLS_NOP   = 3'd0,
    CLS_ARITH = 3'd1,
    CLS_CMP   = 3'd2,
    CLS_LOGIC = 3'd3,
    CLS_WAIT  = 3'd4
  } op_class_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } halt_state_e;

  // Exact register-form opcodes first; immediate forms are recognised by upper nibble.
  function automatic op_class_e decode_class(input logic [7:0] op);
    op_class_e cls;
    cls = CLS_NOP;
    case (op)
      OP_WAIT:                                     cls = CLS_WAIT;
      OP_AND, OP_OR, OP_XOR, OP_LSH,
      OP_RSH, OP_ALSH, OP_ARSH, OP_LSHI:           cls = CLS_LOGIC;
      OP_ADD, OP_ADDU, OP_ADDC, OP_SUB:            cls = CLS_ARITH;
      OP_CMP:                                      cls = CLS_CMP;
      default: begin
        case (op[7:4])
          4'h5, 4'h6, 4'h7, 4'h9: cls = CLS_ARITH;
          4'hB:                   cls = CLS_CMP;
          default:                cls = CLS_NOP;
        endcase
      end
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// General register file: synchronous single write port, two combinational
// read ports that return the value being written this cycle (write-first).
module regfile_2r1w
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Storage update; reset clears every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports with bypass of the in-flight write.
  always_comb begin
    rdata_a_o = regs_q[raddr_a_i];
    rdata_b_o = regs_q[raddr_b_i];
    if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_o = wdata_i;
    end else begin
      rdata_a_o = regs_q[raddr_a_i];
    end
    if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_o = wdata_i;
    end else begin
      rdata_b_o = regs_q[raddr_b_i];
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: owns the register file, the PSR and the WAIT halt FSM,
// and arbitrates the single write port between memory loads and ALU results.
module alu_writeback
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [7:0]        wb_opcode,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_dest,
  input  logic [DATA_W-1:0] ld_data,
  output logic [FLAG_W-1:0] psr,
  output logic              halted,
  input  logic              resume
);

  halt_state_e       state_q, state_d;
  logic [FLAG_W-1:0] psr_q, psr_d;
  op_class_e         cls_s;
  logic              halted_s;
  logic              ready_s;
  logic              fire_s;
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  assign cls_s    = decode_class(wb_opcode);
  assign ready_s  = !reset && !halted_s && !ld_valid;
  assign fire_s   = wb_valid && ready_s;
  assign wb_ready = ready_s;
  assign halted   = halted_s;
  assign psr      = psr_q;

  // Write-port arbitration: a load always wins over an ALU result.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = ld_dest;
    wr_data_s = ld_data;
    if (reset) begin
      wr_en_s = 1'b0;
    end else if (ld_valid) begin
      wr_en_s   = 1'b1;
      wr_addr_s = ld_dest;
      wr_data_s = ld_data;
    end else if (fire_s && ((cls_s == CLS_ARITH) || (cls_s == CLS_LOGIC))) begin
      wr_en_s   = 1'b1;
      wr_addr_s = wb_dest;
      wr_data_s = alu_c;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  regfile_2r1w u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (wr_en_s),
    .waddr_i   (wr_addr_s),
    .wdata_i   (wr_data_s),
    .raddr_a_i (rd_addr_a),
    .raddr_b_i (rd_addr_b),
    .rdata_a_o (rd_data_a),
    .rdata_b_o (rd_data_b)
  );

  // PSR next value: each class owns a different slice of the flags.
  always_comb begin
    psr_d = psr_q;
    if (fire_s) begin
      case (cls_s)
        CLS_ARITH: psr_d[PSR_Z:PSR_F] = alu_flags[PSR_Z:PSR_F];
        CLS_CMP:   psr_d[PSR_N:PSR_L] = alu_flags[PSR_N:PSR_L];
        CLS_LOGIC: psr_d[PSR_Z]       = alu_flags[PSR_Z];
        default:   psr_d              = psr_q;
      endcase
    end else begin
      psr_d = psr_q;
    end
  end

  // PSR register.
  always_ff @(posedge clk) begin
    if (reset) begin
      psr_q <= {FLAG_W{1'b0}};
    end else begin
      psr_q <= psr_d;
    end
  end

  // Halt FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Halt FSM next state; resume only matters once already halted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (fire_s && (cls_s == CLS_WAIT)) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (resume) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Halt FSM outputs.
  always_comb begin
    halted_s = 1'b0;
    case (state_q)
      ST_HALT: halted_s = 1'b1;
      ST_RUN:  halted_s = 1'b0;
      default: halted_s = 1'b0;
    endcase
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Execute-stage consumer directly downstream of the 16-bit ALU.
- Holds the 16-entry general register file and the processor status register (PSR: Z,C,F,N,L).
- Drives the ALU's A/B operands through two read ports and commits ALU result C and Flags per opcode class.
- Arbitrates the single write port against memory-load writeback and implements the WAIT halt state.

Parameters:
- NUM_REGS, 16, number of general registers; address width is log2(NUM_REGS).
- DATA_W, 16, register and ALU data width.
- FLAG_W, 5, PSR width; bit order Z=4, C=3, F=2, N=1, L=0.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high.
- rd_addr_a  in  4  read port A address.
- rd_addr_b  in  4  read port B address.
- rd_data_a  out  16  register A value, to ALU A.
- rd_data_b  out  16  register B value, to ALU B.
- wb_valid  in  1  ALU result present this cycle.
- wb_ready  out  1  result accepted this cycle.
- wb_opcode  in  8  opcode of the presented result.
- wb_dest  in  4  destination register.
- alu_c  in  16  ALU result.
- alu_flags  in  5  ALU flags (ZCFNL).
- ld_valid  in  1  memory-load write request.
- ld_dest  in  4  load destination.
- ld_data  in  16  load data.
- psr  out  5  current PSR; psr[3] is the carry-in for ADDC/ADDCU.
- halted  out  1  WAIT state active.
- resume  in  1  single-cycle pulse that leaves the WAIT state.

Behaviour:
- Reset: all registers 0, psr=0, halted=0, wb_ready=0 during the reset cycle. Reset mid-halt clears halted.
- Reads are combinational with write-first bypass. If a write commits this cycle to the address being read, rd_data returns the new value.
- wb_ready = !reset && !halted && !ld_valid.
  - Load writes have priority on the write port.
  - A result is accepted ("fires") only when wb_valid && wb_ready. Upstream holds opcode, dest, c and flags stable until accepted.
- ld_valid is always accepted: next edge regs[ld_dest] <= ld_data. The PSR is unchanged.
- Opcode classes on fire (decoded by package function):
  - ARITH (ADD 0x05, ADDU 0x06, ADDC 0x07, SUB 0x09, and immediate forms with upper nibble 5/6/7/9): regs[dest] <= alu_c; psr[4:2] <= alu_flags[4:2]; psr[1:0] unchanged.
  - CMP (0x0B, upper nibble B): no register write; psr[1:0] <= alu_flags[1:0]; psr[4:2] unchanged.
  - LOGIC/SHIFT (AND 0x01, OR 0x02, XOR 0x03, shift opcodes 0x04, 0x0C, 0x0D, 0x0E, 0x84): regs[dest] <= alu_c; psr[4] <= alu_flags[4]; other PSR bits unchanged.
  - WAIT (0x00): no register write and no PSR change; halted <= 1 on the next edge.
  - Any other opcode (NOP/unknown): accepted and discarded; no state change.
- Latency: one cycle from fire to register/PSR update. The write is visible on the read ports in the same cycle via bypass.
- Halt state machine, two states:
  - RUN: WAIT fires -> HALT.
  - HALT: resume -> RUN on the next edge. Until then wb_ready=0; ld writes still commit; reads still work.
  - resume while in RUN is ignored.
  - resume in the same cycle a WAIT fires is ignored; the block enters HALT.
- Simultaneous ld_valid and wb_valid: the load commits and the result stalls (wb_ready=0). The result commits on the first cycle ld_valid is low.
- Address wrap: addresses are exactly 4 bits, so there is no out-of-range case.

Decomposition:
- Shared package alu_pkg:
  - opcode constants;
  - PSR bit indices (Z,C,F,N,L);
  - opcode-class enumeration;
  - decode function opcode -> class.
- The ALU consumes the same constants.
- One sub-module, regfile_2r1w: 16x16 storage, synchronous write, combinational reads with write-first bypass.
- The PSR and the halt state machine stay in the top module.

Test Plan:
- Reset then read r0..r15 -> all 0x0000; psr=0; halted=0.
- Fire ADD (0x05), dest=3, c=0x1234, flags=5'b00100 -> next cycle r3=0x1234 and psr=5'b00100. Same-cycle bypass read of r3 returns 0x1234.
- Preload psr=5'b10100, then fire CMP (0x0B), flags=5'b00011, dest=7 -> r7 unchanged; psr=5'b10111.
- Hold wb_valid (ADD, dest=2, c=0xBEEF) while ld_valid writes r2=0x0001 -> wb_ready=0 that cycle, r2=0x0001. The next cycle ADD commits, r2=0xBEEF.
- Fire WAIT (0x00) -> halted=1 and wb_ready=0 for 5 cycles with wb_valid held. A load writes r9=0x00AA during the halt. Pulse resume -> halted=0 and the pending result commits.
- Assert reset mid-halt with r5=0xFFFF -> halted=0, r5=0, psr=0 next cycle.
